ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of the ID/EX register and consumes that register's control and data outputs.
- Each cycle it performs ALU-control decode, ALU operation, branch-target add and destination-register select, then registers the results into the EX/MEM outputs.
- It contains an iterative 32-cycle unsigned multiplier (MULTU) with HI/LO registers. The multiplier stalls upstream stages while it is busy.

---
 rtl/ex_stage.sv | 186 ++++++++++++++++++
 tb/tb_ex_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch-target add, dest select, EX/MEM register, iterative MULTU with HI/LO.
// Latency 1 for normal ops; MULTU holds stall high for 33 cycles, retires in the DONE cycle.
// Backpressure: stall (combinational) freezes PC, IF/ID and ID/EX; flush overrides it and aborts a multiply.
module ex_stage #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       wb_ctl,
    input  logic [2:0]       m_ctl,
    input  logic             regdst,
    input  logic             alusrc,
    input  logic [1:0]       aluop,
    input  logic [WIDTH-1:0] npc,
    input  logic [WIDTH-1:0] rdata1,
    input  logic [WIDTH-1:0] rdata2,
    input  logic [WIDTH-1:0] s_extend,
    input  logic [4:0]       instr_2016,
    input  logic [4:0]       instr_1511,
    output logic             stall,
    output logic [1:0]       wb_ctlout,
    output logic [2:0]       m_ctlout,
    output logic [WIDTH-1:0] add_result,
    output logic             zero,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] rdata2out,
    output logic [4:0]       muxout,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int              CW   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST = CW'(MUL_CYCLES - 1);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  op_b, alu_res, add_res;
    logic [5:0]        funct;
    logic              is_multu;
    logic [4:0]        dest;
    logic [WIDTH-1:0]  mcand, mplier, acc;
    logic [CW-1:0]     count;
    logic [WIDTH:0]    addend, sum;
    logic              stall_c, start, step, bubble, retire;

    always_comb begin
        op_b     = alusrc ? s_extend : rdata2;
        funct    = s_extend[5:0];
        is_multu = (aluop == 2'b10) && (funct == F_MULTU);
        alu_res  = '0;
        case (aluop)
            2'b01: alu_res = rdata1 - op_b;
            2'b10: begin
                case (funct)
                    F_ADD:   alu_res = rdata1 + op_b;
                    F_SUB:   alu_res = rdata1 - op_b;
                    F_AND:   alu_res = rdata1 & op_b;
                    F_OR:    alu_res = rdata1 | op_b;
                    F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(rdata1) < $signed(op_b)};
                    F_MULTU: alu_res = lo;
                    F_MFHI:  alu_res = hi;
                    F_MFLO:  alu_res = lo;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = rdata1 + op_b;
        endcase
        add_res = npc + (s_extend << 2);
        dest    = regdst ? instr_1511 : instr_2016;
    end

    // One shift-add step: {acc, mplier} holds the running 64-bit product.
    always_comb begin
        addend = mplier[0] ? {1'b0, mcand} : '0;
        sum    = {1'b0, acc} + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (is_multu) state_nxt = BUSY;
            BUSY:    if (count == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_comb begin
        stall_c = 1'b0;
        start   = 1'b0;
        step    = 1'b0;
        bubble  = 1'b0;
        retire  = 1'b0;
        if (flush) begin
            bubble = 1'b1;
        end else begin
            case (state)
                IDLE: if (is_multu) begin
                    stall_c = 1'b1;
                    start   = 1'b1;
                    bubble  = 1'b1;
                end
                BUSY: begin
                    stall_c = 1'b1;
                    step    = 1'b1;
                    bubble  = 1'b1;
                end
                DONE:    retire = 1'b1;
                default: bubble = 1'b1;
            endcase
        end
    end

    // Held low during reset so a multu sitting on the inputs cannot freeze upstream.
    assign stall = rst_n & stall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (start) begin
            mcand  <= rdata1;
            mplier <= op_b;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            acc    <= sum[WIDTH:1];
            mplier <= {sum[0], mplier[WIDTH-1:1]};
            count  <= count + CW'(1);
            if (count == LAST) begin
                hi <= sum[WIDTH:1];
                lo <= {sum[0], mplier[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ctlout  <= '0;
            m_ctlout   <= '0;
            add_result <= '0;
            zero       <= 1'b0;
            alu_result <= '0;
            rdata2out  <= '0;
            muxout     <= '0;
        end else if (bubble) begin
            wb_ctlout  <= '0;
            m_ctlout   <= '0;
            add_result <= '0;
            zero       <= 1'b0;
            alu_result <= '0;
            rdata2out  <= '0;
            muxout     <= '0;
        end else begin
            // A retiring multu writes only HI/LO, never the register file.
            wb_ctlout  <= retire ? {1'b0, wb_ctl[0]} : wb_ctl;
            m_ctlout   <= m_ctl;
            add_result <= add_res;
            zero       <= (alu_res == '0);
            alu_result <= alu_res;
            rdata2out  <= rdata2;
            muxout     <= dest;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM words queued at drive time, popped one edge later.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  wb_ctl = '0;
    logic [2:0]  m_ctl = '0;
    logic        regdst = 1'b0;
    logic        alusrc = 1'b0;
    logic [1:0]  aluop = '0;
    logic [31:0] npc = '0, rdata1 = '0, rdata2 = '0, s_extend = '0;
    logic [4:0]  instr_2016 = '0, instr_1511 = '0;
    logic        stall, zero;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [31:0] add_result, alu_result, rdata2out, hi, lo;
    logic [4:0]  muxout;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add;
        logic        z;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  mux;
    } out_t;

    int   checks = 0;
    int   failures = 0;
    out_t sb[$];

    ex_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
        .regdst(regdst), .alusrc(alusrc), .aluop(aluop), .npc(npc), .rdata1(rdata1),
        .rdata2(rdata2), .s_extend(s_extend), .instr_2016(instr_2016), .instr_1511(instr_1511),
        .stall(stall), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .add_result(add_result),
        .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out), .muxout(muxout),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic out_t observe();
        return {wb_ctlout, m_ctlout, add_result, zero, alu_result, rdata2out, muxout};
    endfunction

    function automatic out_t ex(input logic [1:0] w, input logic [2:0] m, input logic [31:0] add,
                                input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] mux);
        return {w, m, add, (alu == 32'd0), alu, rd2, mux};
    endfunction

    task automatic drive(input logic [1:0] w, input logic [2:0] m, input logic rsel, input logic src,
                         input logic [1:0] op, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [4:0] t,
                         input logic [4:0] d);
        wb_ctl = w; m_ctl = m; regdst = rsel; alusrc = src; aluop = op; npc = pc;
        rdata1 = a; rdata2 = b; s_extend = imm; instr_2016 = t; instr_1511 = d;
    endtask

    // Waits (bounded) for stall to drop; counts stalled cycles and non-bubble outputs seen.
    task automatic mul_wait(output int cyc, output int bad);
        cyc = 0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (!stall) break;
            cyc++;
            if (i > 0 && observe() !== '0) bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        out_t got;
        #12;
        got = observe();
        checks++; if (got !== '0) begin failures++; $display("FAIL reset_out: got %h want 0", got); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        logic [31:0] fn[6]  = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h3F, 32'h20};
        logic [31:0] ta[6]  = '{32'd5, 32'd5, 32'h0000F0F0, 32'h0000F0F0, 32'd5, 32'hFFFFFFFF};
        logic [31:0] tb[6]  = '{32'd7, 32'd7, 32'h0000FF00, 32'h0000FF00, 32'd7, 32'd1};
        logic [31:0] res[6] = '{32'd12, 32'hFFFFFFFE, 32'h0000F000, 32'h0000FFF0, 32'd0, 32'd0};
        logic [1:0]  ops[2] = '{2'b00, 2'b11};
        out_t got, want;
        for (int i = 0; i < 6; i++) begin
            drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h1000, ta[i], tb[i], fn[i], 5'(i + 9), 5'(i + 3));
            sb.push_back(ex(2'b10, 3'b000, 32'h1000 + fn[i] * 4, res[i], tb[i], 5'(i + 3)));
            @(negedge clk);
            got = observe(); want = sb.pop_front();
            checks++; if (got !== want) begin failures++; $display("FAIL alu_funct%0d: got %h want %h", i, got, want); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 3'b010, 1'b0, 1'b1, ops[i], 32'h2000, 32'h100, 32'hDEAD, 32'h10, 5'd4, 5'd20);
            sb.push_back(ex(2'b11, 3'b010, 32'h2040, 32'h110, 32'hDEAD, 5'd4));
            @(negedge clk);
            got = observe(); want = sb.pop_front();
            checks++; if (got !== want) begin failures++; $display("FAIL alu_imm_op%0d: got %h want %h", i, got, want); end
        end
    endtask

    task automatic test_branch();
        out_t got, want;
        drive(2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h40, 32'h1234, 32'h1234, 32'h3, 5'd5, 5'd6);
        sb.push_back(ex(2'b00, 3'b100, 32'h4C, 32'd0, 32'h1234, 5'd5));
        @(negedge clk);
        got = observe(); want = sb.pop_front();
        checks++; if (got !== want) begin failures++; $display("FAIL branch_fwd: got %h want %h", got, want); end
        s_extend = 32'hFFFFFFFF;
        rdata2 = 32'h1235;
        sb.push_back(ex(2'b00, 3'b100, 32'h3C, 32'hFFFFFFFF, 32'h1235, 5'd5));
        @(negedge clk);
        got = observe(); want = sb.pop_front();
        checks++; if (got !== want) begin failures++; $display("FAIL branch_back: got %h want %h", got, want); end
    endtask

    task automatic test_slt();
        out_t got, want;
        drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h80, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd2);
        sb.push_back(ex(2'b10, 3'b000, 32'h128, 32'd1, 32'd1, 5'd2));
        @(negedge clk);
        got = observe(); want = sb.pop_front();
        checks++; if (got !== want) begin failures++; $display("FAIL slt_neg: got %h want %h", got, want); end
        rdata1 = 32'd1;
        rdata2 = 32'hFFFFFFFF;
        sb.push_back(ex(2'b10, 3'b000, 32'h128, 32'd0, 32'hFFFFFFFF, 5'd2));
        @(negedge clk);
        got = observe(); want = sb.pop_front();
        checks++; if (got !== want) begin failures++; $display("FAIL slt_pos: got %h want %h", got, want); end
    endtask

    task automatic test_multu();
        out_t got, want;
        int   cyc, bad;
        drive(2'b11, 3'b001, 1'b1, 1'b0, 2'b10, 32'h200, 32'hFFFFFFFF, 32'd2, 32'h19, 5'd0, 5'd7);
        mul_wait(cyc, bad);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL mul_stall_cycles: got %0d want 33", cyc); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL mul_bubbles: got %0d non-bubble cycles want 0", bad); end
        checks++; if (hi !== 32'h1) begin failures++; $display("FAIL mul_hi: got %h want 00000001", hi); end
        checks++; if (lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL mul_lo: got %h want fffffffe", lo); end
        sb.push_back(ex(2'b01, 3'b001, 32'h264, 32'hFFFFFFFE, 32'd2, 5'd7));
        @(negedge clk);
        got = observe(); want = sb.pop_front();
        checks++; if (got !== want) begin failures++; $display("FAIL mul_retire: got %h want %h", got, want); end
        drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h300, 32'd0, 32'd0, 32'h10, 5'd0, 5'd8);
        sb.push_back(ex(2'b10, 3'b000, 32'h340, 32'h1, 32'd0, 5'd8));
        @(negedge clk);
        got = observe(); want = sb.pop_front();
        checks++; if (got !== want) begin failures++; $display("FAIL mfhi: got %h want %h", got, want); end
        s_extend = 32'h12;
        sb.push_back(ex(2'b10, 3'b000, 32'h348, 32'hFFFFFFFE, 32'd0, 5'd8));
        @(negedge clk);
        got = observe(); want = sb.pop_front();
        checks++; if (got !== want) begin failures++; $display("FAIL mflo: got %h want %h", got, want); end
    endtask

    task automatic test_abort();
        out_t got, want;
        drive(2'b11, 3'b000, 1'b1, 1'b0, 2'b10, 32'h500, 32'd3, 32'd4, 32'h19, 5'd0, 5'd1);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b want 0", stall); end
        @(negedge clk);
        flush = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        #1;
        got = observe();
        checks++; if (got !== '0) begin failures++; $display("FAIL flush_bubble: got %h want 0", got); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_idle_stall: got %b want 0", stall); end
        repeat (40) @(negedge clk);
        checks++; if (hi !== 32'h1) begin failures++; $display("FAIL flush_hi: got %h want 00000001", hi); end
        checks++; if (lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL flush_lo: got %h want fffffffe", lo); end
        drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h600, 32'd3, 32'd4, 32'h20, 5'd0, 5'd11);
        sb.push_back(ex(2'b10, 3'b000, 32'h680, 32'd7, 32'd4, 5'd11));
        @(negedge clk);
        got = observe(); want = sb.pop_front();
        checks++; if (got !== want) begin failures++; $display("FAIL flush_then_add: got %h want %h", got, want); end
        // Reset in the middle of a multiply.
        drive(2'b11, 3'b000, 1'b1, 1'b0, 2'b10, 32'h700, 32'd3, 32'd4, 32'h19, 5'd0, 5'd1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        got = observe();
        checks++; if (got !== '0) begin failures++; $display("FAIL rst_busy_out: got %h want 0", got); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL rst_busy_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL rst_busy_lo: got %h want 0", lo); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_busy_stall: got %b want 0", stall); end
        @(negedge clk);
        drive(2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_t got, want;
        int   cyc, bad;
        drive(2'b11, 3'b000, 1'b1, 1'b0, 2'b10, 32'h400, 32'd2, 32'd3, 32'h19, 5'd0, 5'd9);
        mul_wait(cyc, bad);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL b2b1_cycles: got %0d want 33", cyc); end
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin failures++; $display("FAIL b2b1_hilo: got %h/%h want 0/6", hi, lo); end
        sb.push_back(ex(2'b01, 3'b000, 32'h464, 32'd6, 32'd3, 5'd9));
        @(negedge clk);
        got = observe(); want = sb.pop_front();
        checks++; if (got !== want) begin failures++; $display("FAIL b2b1_retire: got %h want %h", got, want); end
        drive(2'b11, 3'b000, 1'b1, 1'b0, 2'b10, 32'h404, 32'd5, 32'd7, 32'h19, 5'd0, 5'd10);
        mul_wait(cyc, bad);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL b2b2_cycles: got %0d want 33", cyc); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b2_bubbles: got %0d want 0", bad); end
        checks++; if (hi !== 32'd0 || lo !== 32'd35) begin failures++; $display("FAIL b2b2_hilo: got %h/%h want 0/23", hi, lo); end
        sb.push_back(ex(2'b01, 3'b000, 32'h468, 32'd35, 32'd7, 5'd10));
        @(negedge clk);
        got = observe(); want = sb.pop_front();
        checks++; if (got !== want) begin failures++; $display("FAIL b2b2_retire: got %h want %h", got, want); end
        drive(2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_slt();
        test_multu();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
